imem_banked_loader: RTL

Parametrised successor to the processor's instruction memory, used as the fetch-side store of the KGPRisc core.
- Registered, pipelined read port with a req/valid handshake and configurable latency (1 or 2).
- Runtime write/load port, so programs are loaded without re-elaboration.
- Hardware clear sequencer that fills the array with the NOP word after every reset.
- Out-of-range and misalignment detection on both ports.

---
 rtl/imem_pkg.sv | 28 ++
 rtl/imem_ram_1w1r.sv | 25 ++
 rtl/imem_banked_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction/data memory blocks: NOP fill word,
// sequencer state encoding and the address-to-index legality check.
package imem_pkg;

    localparam int CHK_W = 64;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h003F0000;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic             err;
        logic [CHK_W-1:0] idx;
    } addr_chk_t;

    // Addresses are widened to CHK_W so that no upper bit escapes the range test.
    function automatic addr_chk_t addr_decode(input logic [CHK_W-1:0] addr,
                                              input logic             byte_addr,
                                              input logic [CHK_W-1:0] depth);
        addr_chk_t r;
        r.idx = byte_addr ? (addr >> 2) : addr;
        r.err = (r.idx >= depth) || (byte_addr && (addr[1:0] != 2'b00));
        return r;
    endfunction

endpackage

// File: rtl/imem_ram_1w1r.sv
// Plain storage array: one synchronous write port, one combinational read port.
module imem_ram_1w1r #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_banked_loader.sv
// Fetch-side instruction store: NOP clear sweep after reset, runtime write port,
// pipelined fetch (1 or 2 cycles) with range/alignment error reporting.
module imem_banked_loader
    import imem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 32,
    parameter int RD_LAT    = 1,
    parameter int BYTE_ADDR = 0,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clka,
    input  logic              rst_n,
    output logic              ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err
);

    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [CHK_W-1:0] DEPTH_W   = CHK_W'(DEPTH);
    localparam logic             BYTE_MODE = (BYTE_ADDR != 0);

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              ready_q;
    logic              wr_err_q;
    addr_chk_t         fchk, wchk;
    logic              clearing, wr_legal, accept, fwd;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata, fetch_word;

    assign fchk = addr_decode(CHK_W'(fetch_addr), BYTE_MODE, DEPTH_W);
    assign wchk = addr_decode(CHK_W'(wr_addr), BYTE_MODE, DEPTH_W);

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign clearing  = (state_q == ST_CLEAR);
    assign wr_legal  = wr_en && ready_q && !wchk.err;
    assign ram_we    = rst_n && (clearing || wr_legal);
    assign ram_waddr = clearing ? cnt_q : wchk.idx[IDX_W-1:0];
    assign ram_wdata = clearing ? NOP_WORD : wr_data;

    always_ff @(posedge clka) begin
        if (!rst_n) wr_err_q <= 1'b0;
        else        wr_err_q <= wr_en && (!ready_q || wchk.err);
    end

    imem_ram_1w1r #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk_i   (clka),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (fchk.idx[IDX_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // Write-first: a same-edge legal write to the fetched index wins over the array.
    assign accept     = fetch_req && ready_q;
    assign fwd        = wr_legal && (wchk.idx == fchk.idx);
    assign fetch_word = fchk.err ? NOP_WORD : (fwd ? wr_data : ram_rdata);

    // Stage p0: captured on the accepting edge
    logic              vld_p0_q, err_p0_q;
    logic [DATA_W-1:0] data_p0_q;

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            err_p0_q  <= 1'b0;
            data_p0_q <= NOP_WORD;
        end else begin
            vld_p0_q <= accept;
            err_p0_q <= accept && fchk.err;
            if (accept) data_p0_q <= fetch_word;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            // Stage p1: extra output register, data/err/valid move together
            logic              vld_p1_q, err_p1_q;
            logic [DATA_W-1:0] data_p1_q;

            always_ff @(posedge clka) begin
                if (!rst_n) begin
                    vld_p1_q  <= 1'b0;
                    err_p1_q  <= 1'b0;
                    data_p1_q <= NOP_WORD;
                end else begin
                    vld_p1_q <= vld_p0_q;
                    err_p1_q <= err_p0_q;
                    if (vld_p0_q) data_p1_q <= data_p0_q;
                end
            end

            assign fetch_valid = vld_p1_q;
            assign fetch_err   = err_p1_q;
            assign fetch_data  = data_p1_q;
        end else begin : g_lat1
            assign fetch_valid = vld_p0_q;
            assign fetch_err   = err_p0_q;
            assign fetch_data  = data_p0_q;
        end
    endgenerate

    assign ready  = ready_q;
    assign wr_err = wr_err_q;

endmodule
